fp_issue_wb: RTL and testbench

//  Response end of the FP decode path. Takes decoded FP ops (operands and control already

---
 rtl/fp_issue_wb.sv | 165 ++++++++++++++++
 tb/tb_fp_issue_wb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_wb.sv
// FP issue/writeback stage: issues decoded ops to the FPU, tracks them in an in-order
// tag FIFO, writes results back to the FP or integer RF and accumulates fflags.
module fp_issue_wb #(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     dec_valid_i,
    input  logic                     dec_regwrite_i,
    input  logic                     dec_int_dst_i,
    input  logic [4:0]               dec_waddr_i,
    input  logic [14:0]              dec_raddr_i,
    input  logic [2:0]               dec_rs_used_i,
    output logic                     stall_o,
    output logic                     fpu_in_valid_o,
    input  logic                     fpu_in_ready_i,
    output logic [$clog2(DEPTH)-1:0] fpu_tag_o,
    input  logic                     fpu_out_valid_i,
    output logic                     fpu_out_ready_o,
    input  logic [$clog2(DEPTH)-1:0] fpu_tag_i,
    input  logic [FLEN-1:0]          fpu_result_i,
    input  logic [4:0]               fpu_status_i,
    input  logic                     flush_i,
    output logic                     fpu_flush_o,
    output logic                     fp_rf_we_o,
    output logic [4:0]               fp_rf_waddr_o,
    output logic [FLEN-1:0]          fp_rf_wdata_o,
    output logic                     int_rf_we_o,
    output logic [4:0]               int_rf_waddr_o,
    output logic [XLEN-1:0]          int_rf_wdata_o,
    input  logic                     fflags_clr_i,
    output logic [4:0]               fflags_o,
    output logic                     busy_o,
    output logic                     error_o
);

    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] wptr_q;
    logic [TAG_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DEPTH-1:0] ent_valid_q;
    logic [DEPTH-1:0] ent_regwrite_q;
    logic [DEPTH-1:0] ent_int_dst_q;
    logic [4:0]       ent_waddr_q [DEPTH];
    logic             wb_valid_q;

    logic hazard;
    logic full;
    logic accept;
    logic pop;
    logic head_regwrite;
    logic head_int_dst;

    // RAW check: any in-flight FP write, including the one currently being written back
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int k = 0; k < 3; k++) begin
                if (ent_valid_q[i] && ent_regwrite_q[i] && !ent_int_dst_q[i] &&
                    dec_rs_used_i[k] && (ent_waddr_q[i] == dec_raddr_i[5*k +: 5])) begin
                    hazard = 1'b1;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (fp_rf_we_o && dec_rs_used_i[k] && (fp_rf_waddr_o == dec_raddr_i[5*k +: 5])) begin
                hazard = 1'b1;
            end
        end
    end

    assign full            = (cnt_q == CNT_W'(DEPTH));
    assign fpu_in_valid_o  = dec_valid_i & ~hazard & ~full & ~flush_i;
    assign accept          = fpu_in_valid_o & fpu_in_ready_i;
    assign stall_o         = dec_valid_i & ~accept;
    assign fpu_tag_o       = wptr_q;
    assign fpu_out_ready_o = (cnt_q != '0) & ~flush_i;
    assign pop             = fpu_out_valid_i & fpu_out_ready_o;
    assign fpu_flush_o     = flush_i;
    assign busy_o          = (cnt_q != '0) | wb_valid_q;
    assign head_regwrite   = ent_regwrite_q[rptr_q];
    assign head_int_dst    = ent_int_dst_q[rptr_q];

    // Tag FIFO: wptr doubles as the FPU tag, results must come back in order
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            cnt_q          <= '0;
            ent_valid_q    <= '0;
            ent_regwrite_q <= '0;
            ent_int_dst_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_waddr_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            ent_valid_q <= '0;
        end else begin
            if (accept) begin
                ent_valid_q[wptr_q]    <= 1'b1;
                ent_regwrite_q[wptr_q] <= dec_regwrite_i;
                ent_int_dst_q[wptr_q]  <= dec_int_dst_i;
                ent_waddr_q[wptr_q]    <= dec_waddr_i;
                wptr_q                 <= wptr_q + TAG_W'(1);
            end
            if (pop) begin
                ent_valid_q[rptr_q] <= 1'b0;
                rptr_q              <= rptr_q + TAG_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    // Writeback stage: the registered strobes are the RF write ports
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q     <= 1'b0;
            fp_rf_we_o     <= 1'b0;
            fp_rf_waddr_o  <= '0;
            fp_rf_wdata_o  <= '0;
            int_rf_we_o    <= 1'b0;
            int_rf_waddr_o <= '0;
            int_rf_wdata_o <= '0;
        end else if (flush_i) begin
            wb_valid_q  <= 1'b0;
            fp_rf_we_o  <= 1'b0;
            int_rf_we_o <= 1'b0;
        end else begin
            wb_valid_q  <= pop;
            fp_rf_we_o  <= pop & head_regwrite & ~head_int_dst;
            int_rf_we_o <= pop & head_regwrite & head_int_dst;
            if (pop) begin
                fp_rf_waddr_o  <= ent_waddr_q[rptr_q];
                fp_rf_wdata_o  <= fpu_result_i;
                int_rf_waddr_o <= ent_waddr_q[rptr_q];
                int_rf_wdata_o <= XLEN'(fpu_result_i);
            end
        end
    end

    // Sticky exception flags and protocol error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_o <= '0;
            error_o  <= 1'b0;
        end else begin
            if (pop) begin
                fflags_o <= fflags_clr_i ? fpu_status_i : (fflags_o | fpu_status_i);
            end else if (fflags_clr_i) begin
                fflags_o <= '0;
            end
            if ((pop && (fpu_tag_i != rptr_q)) || (fpu_out_valid_i && (cnt_q == '0))) begin
                error_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_issue_wb.sv
// Bench for fp_issue_wb: directed scenarios plus random traffic, checked against a
// queue-based model of outstanding ops and expected register writes.
module tb_fp_issue_wb;

    localparam int unsigned FLEN  = 32;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 2;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             dec_valid_i = 1'b0;
    logic             dec_regwrite_i = 1'b0;
    logic             dec_int_dst_i = 1'b0;
    logic [4:0]       dec_waddr_i = '0;
    logic [14:0]      dec_raddr_i = '0;
    logic [2:0]       dec_rs_used_i = '0;
    logic             fpu_in_ready_i = 1'b0;
    logic             fpu_out_valid_i = 1'b0;
    logic [TAG_W-1:0] fpu_tag_i = '0;
    logic [FLEN-1:0]  fpu_result_i = '0;
    logic [4:0]       fpu_status_i = '0;
    logic             flush_i = 1'b0;
    logic             fflags_clr_i = 1'b0;

    logic             stall_o, fpu_in_valid_o, fpu_out_ready_o, fpu_flush_o;
    logic [TAG_W-1:0] fpu_tag_o;
    logic             fp_rf_we_o, int_rf_we_o, busy_o, error_o;
    logic [4:0]       fp_rf_waddr_o, int_rf_waddr_o, fflags_o;
    logic [FLEN-1:0]  fp_rf_wdata_o;
    logic [XLEN-1:0]  int_rf_wdata_o;

    fp_issue_wb #(.FLEN(FLEN), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dec_valid_i(dec_valid_i), .dec_regwrite_i(dec_regwrite_i),
        .dec_int_dst_i(dec_int_dst_i), .dec_waddr_i(dec_waddr_i),
        .dec_raddr_i(dec_raddr_i), .dec_rs_used_i(dec_rs_used_i),
        .stall_o(stall_o), .fpu_in_valid_o(fpu_in_valid_o),
        .fpu_in_ready_i(fpu_in_ready_i), .fpu_tag_o(fpu_tag_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_tag_i(fpu_tag_i), .fpu_result_i(fpu_result_i),
        .fpu_status_i(fpu_status_i), .flush_i(flush_i), .fpu_flush_o(fpu_flush_o),
        .fp_rf_we_o(fp_rf_we_o), .fp_rf_waddr_o(fp_rf_waddr_o),
        .fp_rf_wdata_o(fp_rf_wdata_o), .int_rf_we_o(int_rf_we_o),
        .int_rf_waddr_o(int_rf_waddr_o), .int_rf_wdata_o(int_rf_wdata_o),
        .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rw;
        logic       idst;
        logic [4:0] wa;
    } op_t;

    typedef struct {
        logic        idst;
        logic [4:0]  wa;
        logic [31:0] data;
        int          due;
    } wr_t;

    op_t        oq[$];
    wr_t        wq[$];
    int         m_wptr = 0;
    int         m_rptr = 0;
    int         cyc = 0;
    logic [4:0] m_ff = '0;
    logic       m_err = 1'b0;
    logic       m_hs_last = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic m_haz, e_in_valid, e_ready, e_hs;
    op_t  m_op;
    wr_t  m_wr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d", name, cyc);
    endtask

    // Monitor: compares every DUT output against the model, then advances the model
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            chk("reset_ctrl", {stall_o, fpu_in_valid_o, fpu_out_ready_o, fpu_tag_o, fpu_flush_o,
                               fp_rf_we_o, fp_rf_waddr_o, int_rf_we_o, int_rf_waddr_o,
                               fflags_o, busy_o, error_o}, 64'd0);
            chk("reset_data", {fp_rf_wdata_o, int_rf_wdata_o}, 64'd0);
            oq.delete();
            wq.delete();
            m_wptr = 0; m_rptr = 0; m_ff = '0; m_err = 1'b0; m_hs_last = 1'b0;
        end else begin
            m_haz = 1'b0;
            foreach (oq[i]) begin
                for (int k = 0; k < 3; k++) begin
                    if (oq[i].rw && !oq[i].idst && dec_rs_used_i[k] && oq[i].wa == dec_raddr_i[5*k +: 5])
                        m_haz = 1'b1;
                end
            end
            foreach (wq[i]) begin
                for (int k = 0; k < 3; k++) begin
                    if (wq[i].due == cyc && !wq[i].idst && dec_rs_used_i[k] && wq[i].wa == dec_raddr_i[5*k +: 5])
                        m_haz = 1'b1;
                end
            end
            e_in_valid = dec_valid_i && !m_haz && (oq.size() < DEPTH) && !flush_i;
            e_ready    = (oq.size() != 0) && !flush_i;
            chk("in_valid", fpu_in_valid_o, e_in_valid);
            chk("stall", stall_o, dec_valid_i && !(e_in_valid && fpu_in_ready_i));
            chk("out_ready", fpu_out_ready_o, e_ready);
            chk("flush_fwd", fpu_flush_o, flush_i);
            chk("busy", busy_o, (oq.size() != 0) || m_hs_last);
            chk("fflags", fflags_o, m_ff);
            chk("error", error_o, m_err);
            if (e_in_valid) chk("issue_tag", fpu_tag_o, 64'(m_wptr));

            while (wq.size() > 0 && wq[0].due < cyc) begin
                fail_now("wb_missed");
                void'(wq.pop_front());
            end
            if (fp_rf_we_o || int_rf_we_o) begin
                if (wq.size() == 0 || wq[0].due != cyc) begin
                    fail_now("wb_unexpected");
                end else begin
                    m_wr = wq.pop_front();
                    chk("wb_port", {fp_rf_we_o, int_rf_we_o}, m_wr.idst ? 2'b01 : 2'b10);
                    chk("wb_addr", m_wr.idst ? int_rf_waddr_o : fp_rf_waddr_o, m_wr.wa);
                    chk("wb_data", m_wr.idst ? int_rf_wdata_o : fp_rf_wdata_o, m_wr.data);
                end
            end else if (wq.size() > 0 && wq[0].due == cyc) begin
                fail_now("wb_missing");
                void'(wq.pop_front());
            end

            e_hs = e_ready && fpu_out_valid_i;
            if (fpu_out_valid_i && oq.size() == 0) m_err = 1'b1;
            if (flush_i) begin
                oq.delete();
                m_wptr = 0; m_rptr = 0; m_hs_last = 1'b0;
                if (fflags_clr_i) m_ff = '0;
            end else begin
                if (e_hs) begin
                    m_op = oq.pop_front();
                    if (fpu_tag_i != TAG_W'(m_rptr)) m_err = 1'b1;
                    m_rptr = (m_rptr + 1) % DEPTH;
                    if (m_op.rw) begin
                        m_wr.idst = m_op.idst;
                        m_wr.wa   = m_op.wa;
                        m_wr.data = fpu_result_i;
                        m_wr.due  = cyc + 1;
                        wq.push_back(m_wr);
                    end
                    m_ff = fflags_clr_i ? fpu_status_i : (m_ff | fpu_status_i);
                end else if (fflags_clr_i) begin
                    m_ff = '0;
                end
                if (e_in_valid && fpu_in_ready_i) begin
                    m_op = {dec_regwrite_i, dec_int_dst_i, dec_waddr_i};
                    oq.push_back(m_op);
                    m_wptr = (m_wptr + 1) % DEPTH;
                end
                m_hs_last = e_hs;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid_i = 0; dec_regwrite_i = 0; dec_int_dst_i = 0; dec_waddr_i = '0;
        dec_raddr_i = '0; dec_rs_used_i = '0; fpu_in_ready_i = 0; fpu_out_valid_i = 0;
        fpu_tag_i = '0; fpu_result_i = '0; fpu_status_i = '0; flush_i = 0; fflags_clr_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic issue(input logic rw, input logic idst, input logic [4:0] wa,
                         input logic [14:0] ra, input logic [2:0] used);
        dec_valid_i = 1; dec_regwrite_i = rw; dec_int_dst_i = idst; dec_waddr_i = wa;
        dec_raddr_i = ra; dec_rs_used_i = used; fpu_in_ready_i = 1;
    endtask

    task automatic respond(input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic [4:0] st);
        fpu_out_valid_i = 1; fpu_tag_i = tag; fpu_result_i = res; fpu_status_i = st;
    endtask

    initial begin
        do_reset();

        // FADD to f5, result three cycles later
        step(); issue(1, 0, 5'd5, '0, 3'b000);
        step(); idle_inputs();
        step(); step();
        respond(0, 32'h40400000, 5'd0);
        step(); idle_inputs();
        @(negedge clk_i);
        chk("fadd_we", fp_rf_we_o, 1);
        chk("fadd_waddr", fp_rf_waddr_o, 5);
        chk("fadd_data", fp_rf_wdata_o, 32'h40400000);
        chk("fadd_fflags", fflags_o, 0);

        // RAW on f3 through rs2
        step(); issue(1, 0, 5'd3, '0, 3'b000);
        step(); issue(1, 0, 5'd7, {5'd0, 5'd3, 5'd0}, 3'b010);
        @(negedge clk_i); chk("raw_stall_pending", stall_o, 1);
        step(); respond(1, 32'h3f800000, 5'd0);
        @(negedge clk_i); chk("raw_stall_result", stall_o, 1);
        step(); fpu_out_valid_i = 0;
        @(negedge clk_i);
        chk("raw_stall_wb", stall_o, 1);
        chk("raw_wb_we", fp_rf_we_o, 1);
        chk("raw_wb_addr", fp_rf_waddr_o, 3);
        step();
        @(negedge clk_i);
        chk("raw_release", stall_o, 0);
        chk("raw_release_tag", fpu_tag_o, 2);
        step(); idle_inputs();
        step(); respond(2, 32'h00001234, 5'd0);
        step(); idle_inputs();
        step();

        // Full FIFO: fifth op held until a slot frees
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(); issue(1, 0, 5'(10 + i), '0, 3'b000);
        end
        step(); issue(1, 0, 5'd20, '0, 3'b000);
        @(negedge clk_i); chk("full_stall", stall_o, 1);
        step();
        @(negedge clk_i); chk("full_stall_hold", stall_o, 1);
        step(); respond(0, 32'h0000000a, 5'd0);
        @(negedge clk_i); chk("full_stall_on_pop", stall_o, 1);
        step(); fpu_out_valid_i = 0;
        @(negedge clk_i);
        chk("full_issue", stall_o, 0);
        chk("full_issue_tag", fpu_tag_o, 0);
        step(); idle_inputs();
        step(); respond(1, 32'h0000000b, 5'd0);
        step(); respond(2, 32'h0000000c, 5'd0);
        step(); respond(3, 32'h0000000d, 5'd0);
        step(); respond(0, 32'h0000000e, 5'd0);
        step(); idle_inputs();
        step();

        // FCVT.W.S to x10 with invalid flag, then clear fflags
        step(); issue(1, 1, 5'd10, '0, 3'b000);
        step(); idle_inputs();
        step(); respond(1, 32'hFFFFFFFF, 5'b10000);
        step(); idle_inputs();
        @(negedge clk_i);
        chk("cvt_int_we", int_rf_we_o, 1);
        chk("cvt_fp_we", fp_rf_we_o, 0);
        chk("cvt_waddr", int_rf_waddr_o, 10);
        chk("cvt_data", int_rf_wdata_o, 32'hFFFFFFFF);
        chk("cvt_fflags", fflags_o, 5'b10000);
        step(); fflags_clr_i = 1;
        step(); fflags_clr_i = 0;
        @(negedge clk_i); chk("fflags_clr", fflags_o, 0);

        // Out-of-order tag: sticky error, head still written back
        step(); issue(1, 0, 5'd8, '0, 3'b000);
        step(); issue(1, 0, 5'd9, '0, 3'b000);
        step(); idle_inputs();
        step(); respond(3, 32'h00000055, 5'd0);
        step(); idle_inputs();
        @(negedge clk_i);
        chk("tag_err", error_o, 1);
        chk("tag_err_we", fp_rf_we_o, 1);
        chk("tag_err_addr", fp_rf_waddr_o, 8);
        step(); respond(3, 32'h00000066, 5'd0);
        step(); idle_inputs();
        step(); step();
        @(negedge clk_i); chk("tag_err_sticky", error_o, 1);

        // Flush with three outstanding ops
        for (int i = 0; i < 3; i++) begin
            step(); issue(1, 0, 5'(1 + i), '0, 3'b000);
        end
        step(); idle_inputs(); flush_i = 1;
        @(negedge clk_i); chk("flush_fwd_dir", fpu_flush_o, 1);
        step(); flush_i = 0;
        @(negedge clk_i);
        chk("flush_busy", busy_o, 0);
        chk("flush_keeps_err", error_o, 1);
        step(); step(); step();

        // Async reset mid-operation, including a just-accepted result
        for (int i = 0; i < 3; i++) begin
            step(); issue(1, 0, 5'(4 + i), '0, 3'b000);
        end
        step(); idle_inputs(); respond(0, 32'h00000077, 5'd3);
        step(); idle_inputs(); rst_ni = 0;
        @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", error_o, 0);
        step(); rst_ni = 1;
        step(); step(); step();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                idle_inputs();
                rst_ni = 0;
                step();
                rst_ni = 1;
            end else begin
                dec_valid_i     = ($urandom_range(0, 9) < 6);
                dec_regwrite_i  = ($urandom_range(0, 9) < 8);
                dec_int_dst_i   = ($urandom_range(0, 4) == 0);
                dec_waddr_i     = 5'($urandom_range(0, 7));
                dec_raddr_i     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
                dec_rs_used_i   = 3'($urandom);
                fpu_in_ready_i  = ($urandom_range(0, 9) < 7);
                fpu_out_valid_i = (oq.size() > 0) && ($urandom_range(0, 1) == 1);
                fpu_tag_i       = TAG_W'(m_rptr);
                fpu_result_i    = $urandom;
                fpu_status_i    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
                fflags_clr_i    = ($urandom_range(0, 19) == 0);
                flush_i         = !m_hs_last && ($urandom_range(0, 59) == 0);
            end
        end

        // Drain whatever is still outstanding
        step(); idle_inputs();
        for (int n = 0; n < 20; n++) begin
            step();
            if (oq.size() > 0) respond(TAG_W'(m_rptr), $urandom, 5'd0);
            else fpu_out_valid_i = 0;
        end
        step(); idle_inputs();
        step(); step();
        @(negedge clk_i);
        chk("drain_busy", busy_o, 0);
        chk("drain_writes_left", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
